// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Hazard controller for a 5-stage pipeline. Combines load-use,
//               branch-redirect and data-memory-wait requests into per-stage
//               enable/flush controls for the PC, IF/ID, ID/EX, EX/MEM and
//               MEM/WB registers, and sequences memory-wait timeout and
//               redirect fetch-penalty recovery.
// Parameters  : BR_PENALTY  - IF/ID flush cycles after a redirect (0..15)
//               MEM_TIMEOUT - MEM_WAIT cycles before mem_err (1..255)
// Ports       : clk, rst_n (async, active low)
//               lu_stall, lu_flush, br_taken, dmem_req, dmem_ack  (requests)
//               pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
//               exmem_en, memwb_en, memwb_flush                   (controls)
//               mem_err (timeout pulse), ctrl_busy (state != RUN)
//               perf_stall_cnt, perf_flush_cnt, perf_memwait_cnt (32-bit)
// Config      : HAZARD_PERF_CNT_EN - when defined, the perf_* outputs are
//               live saturating counters; otherwise they are tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int BR_PENALTY  = 1,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lu_stall,
    input  logic        lu_flush,
    input  logic        br_taken,
    input  logic        dmem_req,
    input  logic        dmem_ack,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        ifid_flush,
    output logic        idex_en,
    output logic        idex_flush,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic        memwb_flush,
    output logic        mem_err,
    output logic        ctrl_busy,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt,
    output logic [31:0] perf_memwait_cnt
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

    localparam logic [3:0] c_br_penalty  = 4'(BR_PENALTY);
    localparam logic [7:0] c_mem_timeout = 8'(MEM_TIMEOUT);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_redir_cnt;
    logic [3:0] w_redir_cnt_nxt;
    logic [7:0] r_wait_cnt;
    logic [7:0] w_wait_cnt_nxt;
    logic       w_frozen;

    // Once in MEM_WAIT the access is outstanding until ack, so only ack
    // matters there; elsewhere a new wait starts on an unacked request.
    assign w_frozen  = (r_state == ST_MEM_WAIT) ? !dmem_ack : (dmem_req && !dmem_ack);
    assign ctrl_busy = (r_state != ST_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_redir_cnt <= 4'd0;
            r_wait_cnt  <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_redir_cnt <= w_redir_cnt_nxt;
            r_wait_cnt  <= w_wait_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_redir_cnt_nxt = r_redir_cnt;
        w_wait_cnt_nxt  = r_wait_cnt;
        pc_en           = 1'b1;
        ifid_en         = 1'b1;
        ifid_flush      = 1'b0;
        idex_en         = 1'b1;
        idex_flush      = 1'b0;
        exmem_en        = 1'b1;
        memwb_en        = 1'b1;
        memwb_flush     = 1'b0;
        mem_err         = 1'b0;

        if (w_frozen) begin
            // Freeze everything upstream of WB and push a bubble into WB.
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
            if (r_state == ST_MEM_WAIT) begin
                if (r_wait_cnt == c_mem_timeout) begin
                    mem_err        = 1'b1;
                    w_state_nxt    = ST_RUN;
                    w_wait_cnt_nxt = 8'd0;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 8'd1;
                end
            end else begin
                // A wait arriving mid-redirect abandons the remaining penalty.
                w_state_nxt     = ST_MEM_WAIT;
                w_wait_cnt_nxt  = 8'd1;
                w_redir_cnt_nxt = 4'd0;
            end
        end else begin
            // Release cycle of MEM_WAIT behaves like RUN, which lets a branch
            // held by the frozen EX stage be serviced immediately.
            w_wait_cnt_nxt = 8'd0;
            if (br_taken) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                if (c_br_penalty != 4'd0) begin
                    w_state_nxt     = ST_REDIRECT;
                    w_redir_cnt_nxt = c_br_penalty;
                end else begin
                    w_state_nxt     = ST_RUN;
                    w_redir_cnt_nxt = 4'd0;
                end
            end else if (r_state == ST_REDIRECT) begin
                // ID holds a wrong-path instruction, so load-use is ignored.
                ifid_flush      = 1'b1;
                w_redir_cnt_nxt = r_redir_cnt - 4'd1;
                w_state_nxt     = (r_redir_cnt == 4'd1) ? ST_RUN : ST_REDIRECT;
            end else begin
                w_state_nxt = ST_RUN;
                if (lu_stall) begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = lu_flush;
                end
            end
        end

        // Reset holds every pipeline register cleared.
        if (!rst_n) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b1;
            idex_en     = 1'b0;
            idex_flush  = 1'b1;
            exmem_en    = 1'b0;
            memwb_en    = 1'b0;
            memwb_flush = 1'b1;
            mem_err     = 1'b0;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic        w_lu_hon;
    logic        w_br_hon;
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_flush;
    logic [31:0] r_perf_memwait;

    assign w_br_hon = !w_frozen && br_taken;
    assign w_lu_hon = !w_frozen && !br_taken && (r_state != ST_REDIRECT) && lu_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_stall   <= 32'd0;
            r_perf_flush   <= 32'd0;
            r_perf_memwait <= 32'd0;
        end else begin
            if (w_lu_hon && (r_perf_stall != 32'hFFFF_FFFF))
                r_perf_stall <= r_perf_stall + 32'd1;
            if (w_br_hon && (r_perf_flush != 32'hFFFF_FFFF))
                r_perf_flush <= r_perf_flush + 32'd1;
            if ((r_state == ST_MEM_WAIT) && (r_perf_memwait != 32'hFFFF_FFFF))
                r_perf_memwait <= r_perf_memwait + 32'd1;
        end
    end

    assign perf_stall_cnt   = r_perf_stall;
    assign perf_flush_cnt   = r_perf_flush;
    assign perf_memwait_cnt = r_perf_memwait;
`else
    assign perf_stall_cnt   = 32'd0;
    assign perf_flush_cnt   = 32'd0;
    assign perf_memwait_cnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Self-checking bench for pipe_hazard_ctrl. Two instances share
//               stimulus: u_a (BR_PENALTY=2, MEM_TIMEOUT=6) and
//               u_b (BR_PENALTY=0, MEM_TIMEOUT=4). A behavioural model tracks
//               "cycles spent waiting" and "redirect cycles left" per instance
//               and is compared every falling edge; literal checks pin it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic lu_stall, lu_flush, br_taken, dmem_req, dmem_ack;

    // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
    //  memwb_en, memwb_flush, mem_err, ctrl_busy}
    logic [9:0]  a_o, b_o;
    logic [31:0] a_ps, a_pf, a_pm, b_ps, b_pf, b_pm;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.BR_PENALTY(2), .MEM_TIMEOUT(6)) u_a (
        .clk(clk), .rst_n(rst_n), .lu_stall(lu_stall), .lu_flush(lu_flush),
        .br_taken(br_taken), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
        .pc_en(a_o[9]), .ifid_en(a_o[8]), .ifid_flush(a_o[7]), .idex_en(a_o[6]),
        .idex_flush(a_o[5]), .exmem_en(a_o[4]), .memwb_en(a_o[3]),
        .memwb_flush(a_o[2]), .mem_err(a_o[1]), .ctrl_busy(a_o[0]),
        .perf_stall_cnt(a_ps), .perf_flush_cnt(a_pf), .perf_memwait_cnt(a_pm));

    pipe_hazard_ctrl #(.BR_PENALTY(0), .MEM_TIMEOUT(4)) u_b (
        .clk(clk), .rst_n(rst_n), .lu_stall(lu_stall), .lu_flush(lu_flush),
        .br_taken(br_taken), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
        .pc_en(b_o[9]), .ifid_en(b_o[8]), .ifid_flush(b_o[7]), .idex_en(b_o[6]),
        .idex_flush(b_o[5]), .exmem_en(b_o[4]), .memwb_en(b_o[3]),
        .memwb_flush(b_o[2]), .mem_err(b_o[1]), .ctrl_busy(b_o[0]),
        .perf_stall_cnt(b_ps), .perf_flush_cnt(b_pf), .perf_memwait_cnt(b_pm));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // w: cycles already spent in the wait (0 = no outstanding wait)
    // r: redirect flush cycles still owed
    int m_w[2], m_r[2];
    int m_stall[2], m_flush[2], m_mw[2];
    int c_pen[2] = '{2, 0};
    int c_to[2]  = '{6, 4};

    task automatic m_eval(input int w, input int r, input int pen, input int to,
                          output logic [9:0] o, output int wn, output int rn,
                          output bit luh, output bit brh);
        logic pc, ie, ifl, de, dfl, xe, me, mfl, err;
        pc = 1; ie = 1; ifl = 0; de = 1; dfl = 0; xe = 1; me = 1; mfl = 0; err = 0;
        wn = 0; rn = r; luh = 0; brh = 0;
        if (!rst_n) begin
            o  = 10'b0010100100;
            rn = 0;
        end else begin
            if ((w > 0 && !dmem_ack) || (w == 0 && dmem_req && !dmem_ack)) begin
                pc = 0; ie = 0; de = 0; xe = 0; mfl = 1; rn = 0;
                if (w == to) err = 1;
                else         wn  = w + 1;
            end else if (br_taken) begin
                ifl = 1; dfl = 1; rn = pen; brh = 1;
            end else if (r > 0) begin
                ifl = 1; rn = r - 1;
            end else if (lu_stall) begin
                pc = 0; ie = 0; dfl = lu_flush; luh = 1;
            end
            o = {pc, ie, ifl, de, dfl, xe, me, mfl, err, (w > 0 || r > 0)};
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        logic [9:0] o;
        int wn, rn;
        bit luh, brh;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_w[i] <= 0; m_r[i] <= 0;
                m_stall[i] <= 0; m_flush[i] <= 0; m_mw[i] <= 0;
            end else begin
                m_eval(m_w[i], m_r[i], c_pen[i], c_to[i], o, wn, rn, luh, brh);
                m_w[i] <= wn;
                m_r[i] <= rn;
                if (luh) m_stall[i] <= m_stall[i] + 1;
                if (brh) m_flush[i] <= m_flush[i] + 1;
                if (m_w[i] > 0) m_mw[i] <= m_mw[i] + 1;
            end
        end
    end

    bit chk_en = 1'b0;

    always @(negedge clk) begin
        logic [9:0] oa, ob;
        int wn, rn;
        bit luh, brh;
        if (chk_en) begin
            m_eval(m_w[0], m_r[0], c_pen[0], c_to[0], oa, wn, rn, luh, brh);
            m_eval(m_w[1], m_r[1], c_pen[1], c_to[1], ob, wn, rn, luh, brh);
            chk("model_a", {22'd0, a_o}, {22'd0, oa});
            chk("model_b", {22'd0, b_o}, {22'd0, ob});
`ifdef HAZARD_PERF_CNT_EN
            chk("perf_a", a_ps ^ (a_pf << 1) ^ (a_pm << 2),
                m_stall[0] ^ (m_flush[0] << 1) ^ (m_mw[0] << 2));
            chk("perf_b", b_ps ^ (b_pf << 1) ^ (b_pm << 2),
                m_stall[1] ^ (m_flush[1] << 1) ^ (m_mw[1] << 2));
`else
            chk("perf_a", a_ps | a_pf | a_pm, 32'd0);
            chk("perf_b", b_ps | b_pf | b_pm, 32'd0);
`endif
        end
    end

    // One cycle: drive just after the rising edge, return at the falling edge.
    task automatic cyc(input logic lu, input logic luf, input logic br,
                       input logic req, input logic ack);
        @(posedge clk);
        #1;
        lu_stall = lu; lu_flush = luf; br_taken = br; dmem_req = req; dmem_ack = ack;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        lu_stall = 0; lu_flush = 0; br_taken = 0; dmem_req = 0; dmem_ack = 0;
        chk_en = 1'b1;
        cyc(0, 0, 0, 0, 0);
        chk("rst_pc_en", a_o[9], 0);
        chk("rst_flushes", {a_o[7], a_o[5], a_o[2]}, 3'b111);
        chk("rst_busy", a_o[0], 0);
        rst_n = 1'b1;
        cyc(0, 0, 0, 0, 0);
        chk("run_idle", {22'd0, a_o}, 32'b11_0101_1000);

        // load-use with bubble, then plain stall
        cyc(1, 1, 0, 0, 0);
        chk("lu_pc_ifid", {a_o[9], a_o[8]}, 2'b00);
        chk("lu_idex_flush", a_o[5], 1);
        chk("lu_exmem_en", a_o[4], 1);
        cyc(0, 0, 0, 0, 0);
        chk("lu_after_pc_en", a_o[9], 1);
        cyc(1, 0, 0, 0, 0);
        chk("lu_noflush", a_o[5], 0);

        // branch: u_a owes two more IF/ID flush cycles, u_b none
        cyc(0, 0, 1, 0, 0);
        chk("br_flushes", {a_o[9], a_o[7], a_o[5]}, 3'b111);
        cyc(0, 0, 0, 0, 0);
        chk("br_pen1_a", {a_o[7], a_o[0]}, 2'b11);
        chk("br_pen1_b", {b_o[7], b_o[0]}, 2'b00);
        cyc(1, 1, 0, 0, 0);
        chk("br_pen2_lu_ignored", {a_o[9], a_o[8], a_o[7], a_o[5], a_o[0]}, 5'b11101);
        cyc(0, 0, 0, 0, 0);
        chk("br_done", {a_o[7], a_o[0]}, 2'b00);

        // memory wait: five unacked cycles, ack on the sixth
        for (int i = 1; i <= 5; i++) begin
            cyc(0, 0, 0, 1, 0);
            if (i == 3) chk("mw_freeze", {a_o[9], a_o[4], a_o[3], a_o[2]}, 4'b0011);
            if (i == 4) chk("mw_b_no_err", b_o[1], 0);
        end
        chk("mw_b_timeout", b_o[1], 1);
        chk("mw_a_no_err", a_o[1], 0);
        cyc(0, 0, 0, 1, 1);
        chk("mw_release", {a_o[9], a_o[2], a_o[0]}, 3'b101);
        cyc(0, 0, 0, 0, 0);
        chk("mw_after", a_o[0], 0);

        // timeout with no ack and request dropped afterwards
        for (int i = 1; i <= 5; i++) cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);
        chk("to_b_run", {b_o[1], b_o[0]}, 2'b00);
        cyc(0, 0, 0, 0, 0);
        chk("to_a_err", a_o[1], 1);
        cyc(0, 0, 0, 0, 0);
        chk("to_a_run", {a_o[1], a_o[0]}, 2'b00);

        // collision: branch beats load-use
        cyc(1, 1, 1, 0, 0);
        chk("coll_br_wins", {a_o[9], a_o[8], a_o[7]}, 3'b111);
        repeat (3) cyc(0, 0, 0, 0, 0);

        // branch held during MEM_WAIT, serviced on the ack cycle
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 1, 1, 0);
        chk("br_in_mw_frozen", a_o[9], 0);
        cyc(0, 0, 1, 1, 1);
        chk("br_on_ack", {a_o[9], a_o[7], a_o[5], a_o[4]}, 4'b1111);
        cyc(0, 0, 0, 0, 0);
        chk("br_on_ack_pen", a_o[7], 1);
        // wait arriving in REDIRECT
        cyc(0, 0, 0, 1, 0);
        chk("mw_in_redir", {a_o[9], a_o[7], a_o[0]}, 3'b001);
        cyc(0, 0, 0, 1, 1);
        repeat (2) cyc(0, 0, 0, 0, 0);

        // reset asserted in the middle of a memory wait
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_mw", {22'd0, a_o}, 32'b00_1010_0100);
        dmem_req = 0;
        rst_n = 1'b1;
        cyc(0, 0, 0, 0, 0);
        chk("rst_release", {22'd0, a_o}, 32'b11_0101_1000);

        // mixed traffic, checked against the model only
        for (int i = 0; i < 400; i++) begin
            logic lu;
            lu = ($urandom_range(0, 3) == 0);
            cyc(lu, lu & $urandom_range(0, 1), ($urandom_range(0, 4) == 0),
                ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0));
        end
        cyc(0, 0, 0, 0, 1);
        repeat (3) cyc(0, 0, 0, 0, 0);
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
